// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store sequencer between the processor datapath
// and a word-addressed memory with one-cycle registered read data.
// Byte/halfword/word accesses are byte-addressed on the request side; sub-word
// stores become read-modify-write sequences against the memory.
//
// Request/response handshake: a request is taken when Start=1 at a rising
// edge while the unit is idle (Busy=0); all request fields are latched on that
// edge and may change afterwards. Start seen while Busy=1 (including the Done
// cycle) is dropped, not queued. Every accepted request ends with exactly one
// cycle of Done=1, with Error qualifying it in the same cycle.
module memory_access_unit #(
  parameter int MEMORY_SIZE = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        SignedLoad,
  input  logic [31:0] ByteAddress,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemReadData,
  output logic        MemWriteEnable,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic [31:0] LoadData,
  output logic        Busy,
  output logic        Done,
  output logic        Error
);

  localparam logic [31:0] MEM_WORDS = 32'(MEMORY_SIZE);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_MRG  = 3'd2,
    S_WR   = 3'd3,
    S_ERR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Current state is kept as a plain named register so checkers can bind to it.
  state_t state;
  state_t state_next;

  // Latched request
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] store_data_q;
  logic        err_q;

  // Merged word for sub-word stores, built in MRG and written in WR
  logic [31:0] merge_q;
  logic [31:0] load_data_q;

  logic        req_illegal;
  logic        start_accept;
  logic [31:0] word_index;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign start_accept = (state == S_IDLE) && Start;
  assign word_index   = {2'b00, addr_q[31:2]};
  assign LoadData     = load_data_q;

  // Legality of the incoming request, judged on the raw inputs at latch time
  always_comb begin
    req_illegal = 1'b0;
    case (Size)
      SZ_HALF: if (ByteAddress[0]) req_illegal = 1'b1;
      SZ_WORD: if (ByteAddress[1:0] != 2'b00) req_illegal = 1'b1;
      SZ_BYTE: req_illegal = 1'b0;
      default: req_illegal = 1'b1;
    endcase
    if ({2'b00, ByteAddress[31:2]} >= MEM_WORDS) req_illegal = 1'b1;
  end

  // Lane extraction and sign/zero extension of the word read back in MRG
  always_comb begin
    rd_byte = MemReadData[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = MemReadData[7:0];
      2'd1: rd_byte = MemReadData[15:8];
      2'd2: rd_byte = MemReadData[23:16];
      2'd3: rd_byte = MemReadData[31:24];
      default: rd_byte = MemReadData[7:0];
    endcase
    rd_half = addr_q[1] ? MemReadData[31:16] : MemReadData[15:0];

    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = MemReadData;
    endcase
  end

  // Store merge: replace only the addressed lane, keep every other bit
  always_comb begin
    merged = MemReadData;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = store_data_q[7:0];
        2'd1: merged[15:8]  = store_data_q[7:0];
        2'd2: merged[23:16] = store_data_q[7:0];
        2'd3: merged[31:24] = store_data_q[7:0];
        default: merged = MemReadData;
      endcase
    end else if (size_q == SZ_HALF) begin
      if (addr_q[1]) merged[31:16] = store_data_q[15:0];
      else           merged[15:0]  = store_data_q[15:0];
    end
  end

  // State register; reset aborts any transaction in flight
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and all memory/handshake outputs, decoded from the state
  always_comb begin
    state_next     = state;
    Busy           = 1'b1;
    Done           = 1'b0;
    Error          = 1'b0;
    MemWriteEnable = 1'b0;
    MemAddress     = word_index;
    MemWriteData   = 32'd0;
    case (state)
      S_IDLE: begin
        Busy       = 1'b0;
        MemAddress = 32'd0;
        if (Start) begin
          if (req_illegal)                   state_next = S_ERR;
          else if (IsStore && Size == SZ_WORD) state_next = S_WR;
          else                               state_next = S_RD;
        end
      end
      S_RD:  state_next = S_MRG;
      S_MRG: state_next = is_store_q ? S_WR : S_DONE;
      S_WR: begin
        MemWriteEnable = 1'b1;
        MemWriteData   = (size_q == SZ_WORD) ? store_data_q : merge_q;
        state_next     = S_DONE;
      end
      S_ERR: state_next = S_DONE;
      S_DONE: begin
        Done       = 1'b1;
        Error      = err_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request latch, load result and merge register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= 32'd0;
      store_data_q <= 32'd0;
      err_q        <= 1'b0;
      merge_q      <= 32'd0;
      load_data_q  <= 32'd0;
    end else begin
      if (start_accept) begin
        is_store_q   <= IsStore;
        size_q       <= Size;
        signed_q     <= SignedLoad;
        addr_q       <= ByteAddress;
        store_data_q <= StoreData;
        err_q        <= req_illegal;
      end
      if (state == S_MRG) begin
        if (is_store_q) merge_q     <= merged;
        else            load_data_q <= load_ext;
      end
    end
  end

endmodule
